// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller driving an external 1-bit full adder, LSB first.
// Optional subtract support is enabled with the SERIAL_ADDER_SUB_EN macro.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             mode,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept, last_bit;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1; final carry then reads as "no borrow".
  assign b_load     = mode ? ~op_b : op_b;
  assign carry_load = mode ? 1'b1  : cin;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign b_load      = op_b;
  assign carry_load  = cin;
`endif

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == RUN) && (bit_cnt == LAST_BIT);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        fa_a   = a_sr[0];
        fa_b   = b_sr[0];
        fa_cin = carry;
        if (bit_cnt == LAST_BIT) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result and cout are captured on the edge that enters DONE, using the
  // final full-adder outputs directly, so they are valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sr    <= op_a;
      b_sr    <= b_load;
      carry   <= carry_load;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr  <= {fa_sum, sum_sr[WIDTH-1:1]};
      carry   <= fa_cout;
      bit_cnt <= bit_cnt + CNT_W'(1);
      if (last_bit) begin
        result <= {fa_sum, sum_sr[WIDTH-1:1]};
        cout   <= fa_cout;
      end
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add controller that sequences one shared 1-bit full adder to add two WIDTH-bit operands, LSB first, one bit per clock. The full adder stays outside this block; the block drives its a/b/cin inputs and captures its sum/cout outputs. Results are returned with a start/busy/done handshake, which lets a wide add be done on a minimal-area datapath.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥2)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op_a  input  WIDTH  operand A, captured on accepted start
- op_b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- mode  input  1  0 = add, 1 = subtract; captured on accepted start; ignored unless SERIAL_ADDER_SUB_EN is defined
- fa_a  output  1  to full adder input a
- fa_b  output  1  to full adder input b
- fa_cin  output  1  to full adder input cin
- fa_sum  input  1  from full adder sum (combinational)
- fa_cout  input  1  from full adder cout (combinational)
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result is valid
- result  output  WIDTH  sum; held from done until the next accepted start
- cout  output  1  final carry-out; held with result

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0. When start=1, the block loads a_sr←op_a, b_sr←op_b, carry←cin, clears bit_cnt, and goes to RUN.
- RUN: busy=1.
  - fa_a=a_sr[0], fa_b=b_sr[0], fa_cin=carry.
  - Each cycle: a_sr and b_sr shift right, fa_sum shifts into sum_sr at the MSB, carry←fa_cout, bit_cnt++.
  - After bit_cnt reaches WIDTH-1, the block goes to DONE.
- DONE: result←sum_sr, cout←carry, done=1 for exactly one cycle, then back to IDLE.
- fa_a, fa_b and fa_cin are 0 outside RUN.
- start is ignored in RUN and DONE. There is no queueing.
- start held high continuously restarts the add in the IDLE cycle that follows DONE.
- Arithmetic: {cout,result} = op_a + op_b + cin, modulo 2^(WIDTH+1). Bit i of result comes from the full adder in RUN cycle i.
- bit_cnt is ceil(log2(WIDTH)) bits wide and wraps only through the reset on start.

## Timing
- Start sampled at edge E0: RUN occupies cycles E0+1 … E0+WIDTH, DONE occurs at cycle E0+WIDTH+1, and IDLE resumes at E0+WIDTH+2.
- Latency from start to done is WIDTH+1 cycles. Throughput is one add per WIDTH+2 cycles.
- The next start can be accepted in the cycle after done.
- busy rises in the cycle after start is accepted and falls in the same cycle that done rises.
- result and cout update on the edge that enters DONE. They are stable while done=1 and stay stable afterwards.
- Reset values: state=IDLE, busy=0, done=0, result=0, cout=0, fa_a=0, fa_b=0, fa_cin=0; internal shift registers, carry and bit_cnt are 0.
- Reset asserted mid-RUN: the block aborts immediately and asynchronously, no done is produced, and result clears to 0.

## Configuration
- Macro SERIAL_ADDER_SUB_EN.
- Defined: when mode=1 is captured, b_sr loads ~op_b and carry loads 1 (cin is ignored). result = op_a − op_b mod 2^WIDTH, and cout = 1 means no borrow (op_a ≥ op_b).
- Not defined: mode is unconnected internally and every operation is an add.

## Test plan
- WIDTH=8, op_a=0x3C, op_b=0x0F, cin=0, start for one cycle → busy for 8 cycles; done exactly 9 cycles after start with result=0x4B, cout=0.
- op_a=0xFF, op_b=0x01, cin=0 → result=0x00, cout=1. Then op_a=0x00, op_b=0x00, cin=1 → result=0x01, cout=0. Check result stays held between the two operations.
- Pulse start again at RUN cycle 3 with different operands → ignored; the original result is delivered; only one done pulse.
- Assert rst_n=0 at RUN cycle 4 of 0xAA+0x55 → all outputs 0 at once with no done; a subsequent 0x01+0x01 → result=0x02.
- Exhaustive sweep at WIDTH=4 (all op_a, op_b, cin) → {cout,result} matches the reference sum every time. While busy, fa_a/fa_b match the expected operand bit, LSB first.
- With SERIAL_ADDER_SUB_EN, mode=1: 0x10−0x01 → 0x0F, cout=1; 0x01−0x02 → 0xFF, cout=0. Without the macro, mode=1 with 0x10, 0x01 → 0x11.
